// File: rtl/snoop_cache_ctrl_if.sv
// ============================================================================
// Module      : snoop_cache_ctrl_if
// Description : CPU, coherence-bus, snoop and memory-response signals of the
//               snooping cache controller, with controller (slave) and
//               environment (master) views.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface snoop_cache_ctrl_if;
    logic       cpu_req;
    logic       cpu_we;
    logic [2:0] cpu_addr;
    logic [3:0] cpu_wdata;
    logic       cpu_ready;
    logic       cpu_done;
    logic [3:0] cpu_rdata;
    logic       bus_req;
    logic       bus_grant;
    logic [8:0] bus_out;
    logic [8:0] snoop_in;
    logic [8:0] mem_in;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, bus_grant, snoop_in, mem_in,
        output cpu_ready, cpu_done, cpu_rdata, bus_req, bus_out
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, bus_grant, snoop_in, mem_in,
        input  cpu_ready, cpu_done, cpu_rdata, bus_req, bus_out
    );
endinterface

`default_nettype wire

// File: rtl/snoop_cache_ctrl.sv
// ============================================================================
// Module      : snoop_cache_ctrl
// Description : Direct-mapped MSI snooping cache controller for one CPU port.
//               Optional hit/miss counters enabled by SNOOP_CACHE_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module snoop_cache_ctrl #(
    parameter int LINES  = 4,
    parameter int STAT_W = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    snoop_cache_ctrl_if.slave    cif
`ifdef SNOOP_CACHE_STATS_EN
    ,
    output logic [STAT_W-1:0]    hit_cnt,
    output logic [STAT_W-1:0]    miss_cnt
`endif
);

    localparam int         c_IW       = (LINES > 1) ? $clog2(LINES) : 1;
    localparam logic [1:0] c_LS_I     = 2'd0;
    localparam logic [1:0] c_LS_S     = 2'd1;
    localparam logic [1:0] c_LS_M     = 2'd2;
    localparam logic [1:0] c_MSG_RM   = 2'd0;
    localparam logic [1:0] c_MSG_WB   = 2'd1;
    localparam logic [1:0] c_MSG_INV  = 2'd2;
    localparam logic [8:0] c_BUS_IDLE = 9'h180;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FLUSH = 3'd1,
        ST_WB    = 3'd2,
        ST_RM    = 3'd3,
        ST_WAIT  = 3'd4,
        ST_INV   = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    state_t          r_state, w_next, r_resume, w_resume_nx;
    logic [1:0]      r_lstate [LINES];
    logic [2:0]      r_tag    [LINES];
    logic [3:0]      r_data   [LINES];
    logic            r_we;
    logic [2:0]      r_addr;
    logic [3:0]      r_wdata;
    logic            r_flush_pend;
    logic [2:0]      r_fl_addr;
    logic [3:0]      r_fl_data;
    logic [8:0]      r_bus_out;

    logic [c_IW-1:0] w_req_idx, w_cur_idx, w_snp_idx;
    logic [1:0]      w_snp_msg;
    logic [2:0]      w_snp_addr;
    logic            w_snp_inv, w_snp_rd;
    logic [1:0]      w_req_lst, w_cur_lst;
    logic            w_resume_ld, w_accept, w_hit, w_bus_load, w_flush_clr;
    logic [8:0]      w_bus_msg;
    logic            w_lw_en;
    logic [c_IW-1:0] w_lw_idx;
    logic [1:0]      w_lw_st;
    logic [2:0]      w_lw_tag;
    logic [3:0]      w_lw_data;
    logic            w_unused;

    assign w_req_idx  = cif.cpu_addr[c_IW-1:0];
    assign w_cur_idx  = r_addr[c_IW-1:0];
    assign w_snp_msg  = cif.snoop_in[8:7];
    assign w_snp_addr = cif.snoop_in[6:4];
    assign w_snp_idx  = w_snp_addr[c_IW-1:0];
    assign w_unused   = ^{cif.mem_in[8:4], cif.snoop_in[3:0]} ^ (STAT_W > 0);

    // A second downgrade while a flush is still buffered is refused so the buffer is never lost.
    assign w_snp_inv = (w_snp_msg == c_MSG_INV) && (r_lstate[w_snp_idx] != c_LS_I)
                       && (r_tag[w_snp_idx] == w_snp_addr);
    assign w_snp_rd  = (w_snp_msg == c_MSG_RM) && (r_lstate[w_snp_idx] == c_LS_M)
                       && (r_tag[w_snp_idx] == w_snp_addr) && !r_flush_pend;

    // Line state as it will be after this cycle's snoop, used for all decisions.
    always_comb begin
        w_req_lst = r_lstate[w_req_idx];
        if (w_snp_inv && (w_snp_idx == w_req_idx))     w_req_lst = c_LS_I;
        else if (w_snp_rd && (w_snp_idx == w_req_idx)) w_req_lst = c_LS_S;
        w_cur_lst = r_lstate[w_cur_idx];
        if (w_snp_inv && (w_snp_idx == w_cur_idx))     w_cur_lst = c_LS_I;
        else if (w_snp_rd && (w_snp_idx == w_cur_idx)) w_cur_lst = c_LS_S;
    end

    always_comb begin
        w_next      = r_state;
        w_resume_ld = 1'b0;
        w_resume_nx = r_state;
        w_accept    = 1'b0;
        w_hit       = 1'b0;
        w_bus_load  = 1'b0;
        w_bus_msg   = c_BUS_IDLE;
        w_flush_clr = 1'b0;
        w_lw_en     = 1'b0;
        w_lw_idx    = w_cur_idx;
        w_lw_st     = c_LS_I;
        w_lw_tag    = r_addr;
        w_lw_data   = r_wdata;
        case (r_state)
            ST_IDLE: begin
                if (r_flush_pend) begin
                    w_next      = ST_FLUSH;
                    w_resume_ld = 1'b1;
                end else if (cif.cpu_req) begin
                    w_accept = 1'b1;
                    w_hit    = (w_req_lst != c_LS_I) && (r_tag[w_req_idx] == cif.cpu_addr);
                    if (w_hit) begin
                        if (!cif.cpu_we) begin
                            w_next = ST_DONE;
                        end else if (w_req_lst == c_LS_M) begin
                            w_next    = ST_DONE;
                            w_lw_en   = 1'b1;
                            w_lw_idx  = w_req_idx;
                            w_lw_st   = c_LS_M;
                            w_lw_tag  = cif.cpu_addr;
                            w_lw_data = cif.cpu_wdata;
                        end else begin
                            w_next = ST_INV;
                        end
                    end else if (w_req_lst == c_LS_M) begin
                        w_next = ST_WB;
                    end else begin
                        w_next = ST_RM;
                    end
                end
            end
            ST_FLUSH: begin
                if (cif.bus_grant) begin
                    w_bus_load  = 1'b1;
                    w_bus_msg   = {c_MSG_WB, r_fl_addr, r_fl_data};
                    w_flush_clr = 1'b1;
                    w_next      = r_resume;
                end
            end
            ST_WB: begin
                if (r_flush_pend) begin
                    w_next      = ST_FLUSH;
                    w_resume_ld = 1'b1;
                end else if (cif.bus_grant) begin
                    w_bus_load = 1'b1;
                    w_bus_msg  = {c_MSG_WB, r_tag[w_cur_idx], r_data[w_cur_idx]};
                    w_lw_en    = 1'b1;
                    w_lw_st    = c_LS_I;
                    w_lw_tag   = r_tag[w_cur_idx];
                    w_lw_data  = r_data[w_cur_idx];
                    w_next     = ST_RM;
                end
            end
            ST_RM: begin
                if (r_flush_pend) begin
                    w_next      = ST_FLUSH;
                    w_resume_ld = 1'b1;
                end else if (cif.bus_grant) begin
                    w_bus_load = 1'b1;
                    w_bus_msg  = {c_MSG_RM, r_addr, 4'h0};
                    w_next     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_lw_en   = 1'b1;
                w_lw_st   = c_LS_S;
                w_lw_data = r_we ? r_wdata : cif.mem_in[3:0];
                w_next    = r_we ? ST_INV : ST_DONE;
            end
            ST_INV: begin
                if (r_flush_pend) begin
                    w_next      = ST_FLUSH;
                    w_resume_ld = 1'b1;
                end else if ((w_cur_lst == c_LS_I) || (r_tag[w_cur_idx] != r_addr)) begin
                    // Upgrade lost to a remote invalidate: fetch the line again as a write miss.
                    w_next = ST_RM;
                end else if (cif.bus_grant) begin
                    w_bus_load = 1'b1;
                    w_bus_msg  = {c_MSG_INV, r_addr, r_wdata};
                    w_lw_en    = 1'b1;
                    w_lw_st    = c_LS_M;
                    w_next     = ST_DONE;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_resume     <= ST_IDLE;
            r_we         <= 1'b0;
            r_addr       <= 3'd0;
            r_wdata      <= 4'd0;
            r_flush_pend <= 1'b0;
            r_fl_addr    <= 3'd0;
            r_fl_data    <= 4'd0;
            r_bus_out    <= c_BUS_IDLE;
            for (int i = 0; i < LINES; i++) begin
                r_lstate[i] <= c_LS_I;
                r_tag[i]    <= 3'd0;
                r_data[i]   <= 4'd0;
            end
        end else begin
            r_state   <= w_next;
            r_bus_out <= w_bus_load ? w_bus_msg : c_BUS_IDLE;
            if (w_resume_ld) r_resume <= w_resume_nx;
            if (w_accept) begin
                r_we    <= cif.cpu_we;
                r_addr  <= cif.cpu_addr;
                r_wdata <= cif.cpu_wdata;
            end
            if (w_snp_rd) begin
                r_flush_pend <= 1'b1;
                r_fl_addr    <= w_snp_addr;
                r_fl_data    <= r_data[w_snp_idx];
            end else if (w_flush_clr) begin
                r_flush_pend <= 1'b0;
            end
            if (w_snp_inv)     r_lstate[w_snp_idx] <= c_LS_I;
            else if (w_snp_rd) r_lstate[w_snp_idx] <= c_LS_S;
            // Own line update is written last so a refill beats a same-cycle snoop.
            if (w_lw_en) begin
                r_lstate[w_lw_idx] <= w_lw_st;
                r_tag[w_lw_idx]    <= w_lw_tag;
                r_data[w_lw_idx]   <= w_lw_data;
            end
        end
    end

    assign cif.cpu_ready = (r_state == ST_IDLE) && !r_flush_pend;
    assign cif.cpu_done  = (r_state == ST_DONE);
    assign cif.cpu_rdata = ((r_state == ST_DONE) && !r_we) ? r_data[w_cur_idx] : 4'h0;
    assign cif.bus_req   = (r_state == ST_FLUSH) || (r_state == ST_WB) ||
                           (r_state == ST_RM)    || (r_state == ST_INV);
    assign cif.bus_out   = r_bus_out;

`ifdef SNOOP_CACHE_STATS_EN
    logic [STAT_W-1:0] r_hit_cnt, r_miss_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (w_accept) begin
            if (w_hit && (r_hit_cnt != '1))        r_hit_cnt  <= r_hit_cnt + 1'b1;
            else if (!w_hit && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + 1'b1;
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif

endmodule

`default_nettype wire
